// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: one-hot FSM states,
// default bit timing and frame-length helpers.
package uart_pkg;

  typedef enum logic [4:0] {
    ST_IDLE   = 5'b00001,
    ST_START  = 5'b00010,
    ST_DATA   = 5'b00100,
    ST_PARITY = 5'b01000,
    ST_STOP   = 5'b10000
  } state_t;

  localparam int DEFAULT_CLKS_PER_BIT = 434;  // 50 MHz / 115200 baud
  localparam int START_BITS           = 1;
  localparam int DATA_BITS            = 8;

  // Serial bit periods in one frame, start bit through last stop bit.
  function automatic int frame_bits(input int parity_en, input int stop_bits);
    return START_BITS + DATA_BITS + parity_en + stop_bits;
  endfunction

  function automatic int frame_clks(input int clks_per_bit, input int parity_en,
                                    input int stop_bits);
    return frame_bits(parity_en, stop_bits) * clks_per_bit;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the terminal count
// for one cycle; clear restarts the period from zero.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_done
);

  localparam logic [15:0] TERMINAL = 16'(CLKS_PER_BIT - 1);

  logic [15:0] count_reg;
  logic [15:0] count_next;

  assign bit_done = (count_reg == TERMINAL);

  always_comb begin
    count_next = count_reg + 16'd1;
    if (clear || bit_done) begin
      count_next = 16'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= 16'd0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/uart_serializer.sv
// Byte-to-serial UART transmitter with optional parity and one or two stop
// bits; tx is driven from a register computed from the next FSM state.
module uart_serializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       enable,
  output logic       ready,
  output logic       tx
);

  state_t     state_reg, state_next;
  logic [7:0] shift_reg, shift_next;
  logic [7:0] shifted;
  logic [2:0] bit_idx_reg, bit_idx_next;
  logic       stop_idx_reg, stop_idx_next;
  logic       parity_reg, parity_next;
  logic       tx_reg, tx_next;
  logic       accept;
  logic       baud_clear;
  logic       bit_done;

  assign ready  = (state_reg == ST_IDLE);
  assign accept = ready && enable;
  assign tx     = tx_reg;

  // LSB-first shift toward bit 0, zero fill from the top.
  assign shifted[7] = 1'b0;
  generate
    for (genvar gi = 0; gi < 7; gi++) begin : g_shift
      assign shifted[gi] = shift_reg[gi+1];
    end
  endgenerate

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_gen (
    .clk     (clk),
    .reset   (reset),
    .clear   (baud_clear),
    .bit_done(bit_done)
  );

  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    bit_idx_next  = bit_idx_reg;
    stop_idx_next = stop_idx_reg;
    parity_next   = parity_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next    = ST_START;
          shift_next    = data_in;
          parity_next   = (^data_in) ^ (PARITY_ODD != 0);
          bit_idx_next  = 3'd0;
          stop_idx_next = 1'b0;
        end
      end
      ST_START: begin
        if (bit_done) state_next = ST_DATA;
      end
      ST_DATA: begin
        if (bit_done) begin
          shift_next = shifted;
          if (bit_idx_reg == 3'd7) begin
            state_next = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_done) state_next = ST_STOP;
      end
      ST_STOP: begin
        if (bit_done) begin
          if (STOP_BITS == 1 || stop_idx_reg) begin
            state_next = ST_IDLE;
          end else begin
            stop_idx_next = 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // Line level for the cycle that follows this edge.
    case (state_next)
      ST_START:  tx_next = 1'b0;
      ST_DATA:   tx_next = shift_next[0];
      ST_PARITY: tx_next = parity_next;
      default:   tx_next = 1'b1;
    endcase

    baud_clear = accept || (state_next != state_reg);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      shift_reg    <= 8'd0;
      bit_idx_reg  <= 3'd0;
      stop_idx_reg <= 1'b0;
      parity_reg   <= 1'b0;
      tx_reg       <= 1'b1;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      bit_idx_reg  <= bit_idx_next;
      stop_idx_reg <= stop_idx_next;
      parity_reg   <= parity_next;
      tx_reg       <= tx_next;
    end
  end

endmodule

// File: tb/tb_uart_serializer.sv
// Bench for uart_serializer: four configurations at 4 clocks per bit, with a
// serial decoder on the 8N1 instance checking bytes against a scoreboard.
module tb_uart_serializer;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] en;
  logic [7:0] din [4];
  logic [3:0] rdy;
  logic [3:0] txs;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q [$];
  logic       mon_en  = 1'b1;
  int         mon_cnt = 0;

  always #5 clk = ~clk;

  // 0: 8N1, 1: 8E1, 2: 8O1, 3: 8N2
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
      uart_serializer #(
        .CLKS_PER_BIT(CPB),
        .PARITY_EN   ((gi == 1 || gi == 2) ? 1 : 0),
        .PARITY_ODD  ((gi == 2) ? 1 : 0),
        .STOP_BITS   ((gi == 3) ? 2 : 1)
      ) dut (
        .clk    (clk),
        .reset  (reset),
        .data_in(din[gi]),
        .enable (en[gi]),
        .ready  (rdy[gi]),
        .tx     (txs[gi])
      );
    end
  endgenerate

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference line waveform, one entry per clock, sampled from the cycle after acceptance.
  function automatic logic [63:0] exp_wave(input logic [7:0] b, input int pe, input int po,
                                           input int sb);
    logic [15:0] bits;
    logic [63:0] w;
    int nb;
    bits    = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = b[i];
    if (pe != 0) bits[9] = (^b) ^ (po != 0);
    nb = 9 + pe + sb;
    w  = '0;
    for (int k = 0; k < nb * CPB; k++) w[k] = bits[k/CPB];
    return w;
  endfunction

  task automatic send_measure(input int d, input logic [7:0] b, output int low,
                              output logic [63:0] wave);
    @(negedge clk);
    din[d] = b;
    en[d]  = 1'b1;
    @(negedge clk);
    en[d]  = 1'b0;
    low    = 0;
    wave   = '0;
    while (rdy[d] === 1'b0 && low < 64) begin
      wave[low] = txs[d];
      low++;
      @(negedge clk);
    end
  endtask

  task automatic run_directed(input int d, input logic [7:0] b, input int pe, input int po,
                              input int sb, input string tag, output logic [63:0] wave);
    int low;
    send_measure(d, b, low, wave);
    check({tag, "_busy_len"}, low, (9 + pe + sb) * CPB);
    check({tag, "_wave"}, wave, exp_wave(b, pe, po, sb));
    check({tag, "_idle_tx"}, txs[d], 1'b1);
  endtask

  task automatic wait_ready(input int d, input string tag);
    int n = 0;
    while (rdy[d] !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, rdy[d], 1'b1);
  endtask

  // Serial decoder on the 8N1 line: finds a start bit, samples mid-bit, pops the scoreboard.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (mon_en && txs[0] === 1'b0) begin
        repeat (2) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
          repeat (CPB) @(negedge clk);
          b[k] = txs[0];
        end
        repeat (CPB) @(negedge clk);
        check("mon_stop", txs[0], 1'b1);
        @(negedge clk);
        mon_cnt++;
        check("sb_nonempty", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) check("mon_byte", b, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] wave;
    logic        all_high;
    int          low, hi, n, cnt0;
    string       msg;

    reset = 1'b1;
    en    = 4'b0;
    for (int i = 0; i < 4; i++) din[i] = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_tx", txs, 4'hF);
    check("reset_ready", rdy, 4'hF);
    reset = 1'b0;

    // 8N1 0x48: bits 0,0,0,0,1,0,0,1,0,1
    exp_q.push_back(8'h48);
    run_directed(0, 8'h48, 0, 0, 1, "n81_48", wave);

    run_directed(1, 8'h48, 1, 0, 1, "even_48", wave);
    check("even_parity_bit", wave[37], 1'b0);
    run_directed(2, 8'h48, 1, 1, 1, "odd_48", wave);
    check("odd_parity_bit", wave[37], 1'b1);
    run_directed(3, 8'hFF, 0, 0, 2, "stop2_ff", wave);
    check("stop2_last_stop", wave[43:36], 8'hFF);

    // enable held high, data switched mid-frame
    @(negedge clk);
    exp_q.push_back(8'h41);
    din[0] = 8'h41;
    en[0]  = 1'b1;
    @(negedge clk);
    low = 0;
    while (rdy[0] === 1'b0 && low < 100) begin
      low++;
      if (low == 10) begin
        din[0] = 8'h42;
        exp_q.push_back(8'h42);
      end
      @(negedge clk);
    end
    check("b2b_first_len", low, 40);
    hi = 0;
    while (rdy[0] === 1'b1 && hi < 10) begin
      hi++;
      @(negedge clk);
    end
    check("b2b_idle_cycles", hi, 1);
    en[0] = 1'b0;
    wait_ready(0, "b2b_second_done");

    // reset during a 0x55 frame
    repeat (4) @(negedge clk);
    mon_en = 1'b0;
    din[0] = 8'h55;
    en[0]  = 1'b1;
    @(negedge clk);
    en[0] = 1'b0;
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_tx", txs[0], 1'b1);
    check("abort_ready", rdy[0], 1'b1);
    reset    = 1'b0;
    all_high = 1'b1;
    repeat (8) begin
      @(negedge clk);
      all_high = all_high & txs[0] & rdy[0];
    end
    check("abort_quiet", all_high, 1'b1);
    mon_en = 1'b1;
    exp_q.push_back(8'h55);
    run_directed(0, 8'h55, 0, 0, 1, "resend_55", wave);

    // upstream source: wait for ready low, then ready high, per byte
    msg  = "Hello Cari!";
    cnt0 = mon_cnt;
    for (int i = 0; i < msg.len(); i++) begin
      exp_q.push_back(msg[i]);
      din[0] = msg[i];
      en[0]  = 1'b1;
      n = 0;
      while (rdy[0] !== 1'b0 && n < 10) begin
        @(negedge clk);
        n++;
      end
      check("str_ready_drop", rdy[0], 1'b0);
      en[0] = 1'b0;
      wait_ready(0, "str_ready_rise");
    end
    repeat (4) @(negedge clk);
    check("str_frames", mon_cnt - cnt0, 11);
    check("sb_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
